// File: rtl/rule_depacker_pkg.sv
// Shared types and helpers for the rule-stream depacker.
package rule_depacker_pkg;

   localparam int MAX_LANES = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TERM  = 2'd2
   } state_t;

   // Index of the lowest set bit; 0 for an empty mask.
   function automatic int lowest_set(input logic [MAX_LANES-1:0] m);
      lowest_set = 0;
      for (int i = MAX_LANES - 1; i >= 0; i--)
         if (m[i]) lowest_set = i;
   endfunction

   // Lanes holding at least one valid byte; valid bytes occupy the low end.
   function automatic logic [MAX_LANES-1:0] lane_valid_mask(input int ratio, input int lane_bytes,
                                                             input int empty);
      int vb;
      vb = ratio * lane_bytes - empty;
      lane_valid_mask = '0;
      for (int i = 0; i < MAX_LANES; i++)
         lane_valid_mask[i] = (i < ratio) && (i * lane_bytes < vb);
   endfunction

endpackage

// File: rtl/rule_sc_fifo.sv
// Single-clock show-ahead FIFO with fill level and registered almost-full.
module rule_sc_fifo #(
   parameter int W          = 34,
   parameter int DEPTH      = 64,
   parameter int FULL_LEVEL = 48,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          rd_valid,
   output logic [AW:0]   fill_level,
   output logic          almost_full
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_d;
   logic         af_q, af_d, pop;

   assign fill_level  = wr_ptr_q - rd_ptr_q;
   assign rd_valid    = fill_level != '0;
   assign pop         = rd_en && rd_valid;
   // Data is forced to zero when empty so reset leaves the output bus clean.
   assign rd_data     = rd_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
   assign almost_full = af_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      fill_d   = wr_ptr_d - rd_ptr_d;
      af_d     = fill_d >= (AW+1)'(FULL_LEVEL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         af_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         af_q     <= af_d;
      end
   end

   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && fill_level == (AW+1)'(DEPTH)));

endmodule

// File: rtl/rule_depacker_gen.sv
// Unpacks wide rule beats into one non-zero rule word per cycle, with
// terminator on packet end and FIFO almost-full back-pressure.
module rule_depacker_gen
   import rule_depacker_pkg::*;
#(
   parameter int IN_W       = 64,
   parameter int OUT_W      = 32,
   parameter int EOP_MODE   = 0,
   parameter int FIFO_DEPTH = 64,
   parameter int FULL_LEVEL = 48,
   localparam int RATIO     = IN_W / OUT_W,
   localparam int IE_W      = $clog2(IN_W / 8),
   localparam int OE_W      = (OUT_W / 8 > 1) ? $clog2(OUT_W / 8) : 1,
   localparam int LI_W      = (RATIO > 1) ? $clog2(RATIO) : 1,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_rule_sop,
   input  logic             in_rule_eop,
   input  logic [IE_W-1:0]  in_rule_empty,
   input  logic             in_rule_valid,
   input  logic [IN_W-1:0]  in_rule_data,
   output logic             in_rule_ready,
   output logic             out_rule_sop,
   output logic             out_rule_eop,
   output logic             out_rule_valid,
   output logic [OUT_W-1:0] out_rule_data,
   output logic [OE_W-1:0]  out_rule_empty,
   input  logic             out_rule_ready
);

   state_t                       state_q, state_d;
   logic [RATIO-1:0]             mask_q, mask_d, nz, lv, m_new;
   logic [IN_W-1:0]              data_q, data_d;
   logic                         term_q, term_d, sop_q, sop_d, rdy_en_q;
   logic [RATIO-1:0][OUT_W-1:0]  lanes, in_lanes;
   logic [LI_W-1:0]              lane_idx;
   logic                         last_lane, wr_en, acc, almost_full;
   logic [OUT_W+1:0]             wr_word, rd_word;
   logic [AW:0]                  fill_level;

   assign lanes    = data_q;
   assign in_lanes = in_rule_data;

   for (genvar g = 0; g < RATIO; g++) begin : g_nz
      assign nz[g] = |in_lanes[g];
   end

   assign lv        = RATIO'(lane_valid_mask(RATIO, OUT_W / 8, int'(in_rule_empty)));
   assign m_new     = (EOP_MODE != 0 && in_rule_eop) ? (nz & lv) : nz;
   assign lane_idx  = LI_W'(lowest_set(MAX_LANES'(mask_q)));
   assign last_lane = (mask_q & (mask_q - RATIO'(1))) == '0;
   assign wr_en     = !almost_full && (state_q == ST_DRAIN || state_q == ST_TERM);
   // A pending terminator blocks the no-gap handoff so it can be written first.
   assign in_rule_ready = rdy_en_q && !almost_full &&
                          (state_q == ST_IDLE || (state_q == ST_DRAIN && !term_q && last_lane));
   assign acc       = in_rule_valid && in_rule_ready;
   assign wr_word   = (state_q == ST_TERM) ? {sop_q, 1'b1, {OUT_W{1'b0}}}
                                           : {sop_q, 1'b0, lanes[lane_idx]};

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      data_d  = data_q;
      term_d  = term_q;
      sop_d   = sop_q & ~wr_en;
      if (wr_en) begin
         if (state_q == ST_TERM) begin
            state_d = ST_IDLE;
         end else begin
            mask_d = mask_q & (mask_q - RATIO'(1));
            if (last_lane) begin
               state_d = term_q ? ST_TERM : ST_IDLE;
               term_d  = 1'b0;
            end
         end
      end
      if (acc) begin
         data_d = in_rule_data;
         mask_d = m_new;
         term_d = 1'b0;
         sop_d  = sop_d | in_rule_sop;
         if (in_rule_eop && EOP_MODE == 0) begin
            mask_d  = '0;
            state_d = ST_TERM;
         end else if (in_rule_eop) begin
            state_d = (m_new != '0) ? ST_DRAIN : ST_TERM;
            term_d  = m_new != '0;
         end else begin
            state_d = (m_new != '0) ? ST_DRAIN : ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         data_q   <= '0;
         term_q   <= 1'b0;
         sop_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         data_q   <= data_d;
         term_q   <= term_d;
         sop_q    <= sop_d;
         rdy_en_q <= 1'b1;
      end
   end

   rule_sc_fifo #(.W(OUT_W + 2), .DEPTH(FIFO_DEPTH), .FULL_LEVEL(FULL_LEVEL)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_word),
      .rd_en       (out_rule_ready),
      .rd_data     (rd_word),
      .rd_valid    (out_rule_valid),
      .fill_level  (fill_level),
      .almost_full (almost_full)
   );

   assign {out_rule_sop, out_rule_eop, out_rule_data} = rd_word;
   assign out_rule_empty = '0;

   a_fill_bound: assert property (@(posedge clk) disable iff (rst)
      fill_level <= (AW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_rule_depacker_gen.sv
// Scoreboard bench: u0 is 64->32 discarding EOP data, u1 is 128->32 keeping EOP lanes.
module tb_rule_depacker_gen;

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic        e;
      bit          b2b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   exp_t q0[$], q1[$];

   logic rst0, in0_sop, in0_eop, in0_valid, in0_ready, os0, oe0, ov0, or0;
   logic [2:0] in0_empty;
   logic [63:0] in0_data;
   logic [31:0] od0;
   logic [1:0] oemp0;

   logic rst1, in1_sop, in1_eop, in1_valid, in1_ready, os1, oe1, ov1, or1;
   logic [3:0] in1_empty;
   logic [127:0] in1_data;
   logic [31:0] od1;
   logic [1:0] oemp1;

   rule_depacker_gen #(.IN_W(64), .OUT_W(32), .EOP_MODE(0), .FIFO_DEPTH(64), .FULL_LEVEL(48)) u0 (
      .clk(clk), .rst(rst0), .in_rule_sop(in0_sop), .in_rule_eop(in0_eop),
      .in_rule_empty(in0_empty), .in_rule_valid(in0_valid), .in_rule_data(in0_data),
      .in_rule_ready(in0_ready), .out_rule_sop(os0), .out_rule_eop(oe0),
      .out_rule_valid(ov0), .out_rule_data(od0), .out_rule_empty(oemp0),
      .out_rule_ready(or0));

   rule_depacker_gen #(.IN_W(128), .OUT_W(32), .EOP_MODE(1), .FIFO_DEPTH(64), .FULL_LEVEL(48)) u1 (
      .clk(clk), .rst(rst1), .in_rule_sop(in1_sop), .in_rule_eop(in1_eop),
      .in_rule_empty(in1_empty), .in_rule_valid(in1_valid), .in_rule_data(in1_data),
      .in_rule_ready(in1_ready), .out_rule_sop(os1), .out_rule_eop(oe1),
      .out_rule_valid(ov1), .out_rule_data(od1), .out_rule_empty(oemp1),
      .out_rule_ready(or1));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic void push0(input logic [31:0] d, input logic s, input logic e, input bit b);
      exp_t x;
      x.d = d; x.s = s; x.e = e; x.b2b = b;
      q0.push_back(x);
   endfunction

   function automatic void push1(input logic [31:0] d, input logic s, input logic e);
      exp_t x;
      x.d = d; x.s = s; x.e = e; x.b2b = 0;
      q1.push_back(x);
   endfunction

   // Monitors: one handshake per negedge sample.
   int cyc0 = 0, last0 = -10, cyc1 = 0;
   always @(negedge clk) begin
      exp_t x;
      cyc0++;
      if (ov0 && or0) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_bad++;
            $display("FAIL u0_unexpected: got d=%0h sop=%0b eop=%0b want nothing", od0, os0, oe0);
         end else begin
            x = q0.pop_front();
            if (od0 !== x.d || os0 !== x.s || oe0 !== x.e) begin
               n_bad++;
               $display("FAIL u0_word: got d=%0h sop=%0b eop=%0b want d=%0h sop=%0b eop=%0b",
                        od0, os0, oe0, x.d, x.s, x.e);
            end
            if (x.b2b) begin
               n_cmp++;
               if (cyc0 != last0 + 1) begin
                  n_bad++;
                  $display("FAIL u0_gap: got gap %0d want 1", cyc0 - last0);
               end
            end
         end
         last0 = cyc0;
      end
   end

   always @(negedge clk) begin
      exp_t x;
      cyc1++;
      if (ov1 && or1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL u1_unexpected: got d=%0h sop=%0b eop=%0b want nothing", od1, os1, oe1);
         end else begin
            x = q1.pop_front();
            if (od1 !== x.d || os1 !== x.s || oe1 !== x.e) begin
               n_bad++;
               $display("FAIL u1_word: got d=%0h sop=%0b eop=%0b want d=%0h sop=%0b eop=%0b",
                        od1, os1, oe1, x.d, x.s, x.e);
            end
         end
      end
   end

   task automatic send0(input logic s, input logic e, input logic [63:0] d);
      int t;
      in0_sop = s; in0_eop = e; in0_data = d; in0_valid = 1'b1; t = 0;
      while (!in0_ready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin
         n_cmp++; n_bad++;
         $display("FAIL send0_timeout: got ready=0 want ready=1");
      end
      @(negedge clk);
      in0_valid = 1'b0;
   endtask

   task automatic send1(input logic s, input logic e, input logic [3:0] emp, input logic [127:0] d);
      int t;
      in1_sop = s; in1_eop = e; in1_empty = emp; in1_data = d; in1_valid = 1'b1; t = 0;
      while (!in1_ready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin
         n_cmp++; n_bad++;
         $display("FAIL send1_timeout: got ready=0 want ready=1");
      end
      @(negedge clk);
      in1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got q0=%0d q1=%0d pending want 0", q0.size(), q1.size());
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int k;
      rst0 = 1; rst1 = 1; or0 = 1; or1 = 1;
      in0_valid = 0; in0_sop = 0; in0_eop = 0; in0_empty = 0; in0_data = '0;
      in1_valid = 0; in1_sop = 0; in1_eop = 0; in1_empty = 0; in1_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready0", in0_ready, 0);
      chk("rst_out0", {ov0, os0, oe0, od0}, 0);
      chk("rst_out1", {in1_ready, ov1, os1, oe1, od1}, 0);
      chk("out_empty0", oemp0, 0);
      rst0 = 0; rst1 = 0;
      #1 chk("ready_after_deassert", in0_ready, 0);
      @(negedge clk);
      chk("ready_one_cycle_later", {in0_ready, in1_ready}, 2'b11);

      // Basic unpack, no gap between lanes of one beat.
      push0(1, 1, 0, 0); push0(2, 0, 0, 1); push0(3, 0, 0, 0); push0(0, 0, 1, 0);
      send0(1, 0, 64'h00000002_00000001);
      send0(0, 0, 64'h00000000_00000003);
      send0(0, 1, 64'h0);
      wait_drain();

      // EOP beat data discarded, terminator carries sop.
      push0(0, 1, 1, 0);
      send0(1, 1, 64'h00000003_00000000);
      wait_drain();

      // All-zero SOP beat defers sop to next written word.
      push0(1, 1, 0, 0);
      send0(1, 0, 64'h0);
      send0(0, 0, 64'h1);
      wait_drain();

      // EOP-mode unpack honouring empty bytes.
      push1(5, 1, 0); push1(6, 0, 0); push1(0, 0, 1);
      send1(1, 1, 4'd8, 128'h00000008_00000007_00000006_00000005);
      wait_drain();

      // Back-pressure: output stalled, input continuous.
      or0 = 0; k = 0;
      for (int c = 0; c < 200; c++) begin
         in0_valid = 1; in0_sop = 0; in0_eop = 0;
         in0_data = {32'(2 * k + 2), 32'(2 * k + 1)};
         if (in0_ready) begin
            push0(32'(2 * k + 1), 0, 0, 0);
            push0(32'(2 * k + 2), 0, 0, 0);
            k++;
         end
         @(negedge clk);
      end
      in0_valid = 0;
      chk("bp_beats_accepted", k, 25);
      chk("bp_ready_low", in0_ready, 0);
      chk("bp_head_held", {ov0, od0}, {1'b1, 32'd1});
      or0 = 1;
      wait_drain();
      push0(0, 0, 1, 0);
      send0(0, 1, 64'h0);
      wait_drain();

      // Reset mid-drain drops everything.
      or1 = 0;
      send1(1, 0, 4'd0, 128'h00000004_00000003_00000002_00000001);
      @(negedge clk);
      chk("pre_rst_valid", ov1, 1);
      rst1 = 1;
      #1 chk("async_rst_out", {in1_ready, ov1, os1, oe1, od1}, 0);
      @(negedge clk);
      rst1 = 0;
      #1 chk("rst1_ready_low", in1_ready, 0);
      @(negedge clk);
      chk("rst1_ready_high", in1_ready, 1);
      or1 = 1;
      push1(9, 1, 0); push1(0, 0, 1);
      send1(1, 1, 4'd0, 128'h00000000_00000000_00000000_00000009);
      wait_drain();

      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
